frame_dispatch: RTL and testbench

Forwarding-decision stage between the shared write arbiter and the per-port VOQs. It buffers frame descriptors (source port, source/destination MAC, start block address) that the arbiter emits at end-of-packet. For each descriptor it issues one learn request and one lookup request to the address table, then writes the start pointer into the VOQs of the selected egress ports: unicast, flood, or filter.

---
 rtl/switch_pkg.sv | 35 +++
 rtl/desc_fifo.sv | 48 ++++
 rtl/frame_dispatch.sv | 165 ++++++++++++++++
 tb/tb_frame_dispatch.sv | 450 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/switch_pkg.sv
// Shared types and constants for the switch forwarding path.
// Frame descriptors, dispatch FSM states and MAC helpers live here.
package switch_pkg;

  localparam int unsigned NUM_PORTS = 4;
  localparam int unsigned PORT_W    = $clog2(NUM_PORTS);
  localparam int unsigned ADDR_W    = 10;
  localparam int unsigned MAC_W     = 48;
  localparam int unsigned CNT_W     = 16;

  typedef enum logic [2:0] {
    StIdle,
    StLearn,
    StLookup,
    StWait,
    StEnq
  } dispatch_state_t;

  typedef struct packed {
    logic [PORT_W-1:0] src_port;
    logic [MAC_W-1:0]  src_mac;
    logic [MAC_W-1:0]  dst_mac;
    logic [ADDR_W-1:0] start_addr;
  } frame_desc_t;

  // I/G bit of the first octet on the wire.
  function automatic logic is_group_mac(input logic [MAC_W-1:0] mac);
    return mac[40];
  endfunction

  function automatic logic [NUM_PORTS-1:0] port_onehot(input logic [PORT_W-1:0] port);
    return NUM_PORTS'(1) << port;
  endfunction

endpackage

// File: rtl/desc_fifo.sv
// Synchronous FIFO of frame descriptors between the write arbiter and the dispatch FSM.
// Pushes while full and pops while empty are ignored.
module desc_fifo
  import switch_pkg::*;
#(
  parameter int unsigned Depth = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push_i,
  input  frame_desc_t wdata_i,
  input  logic        pop_i,
  output frame_desc_t rdata_o,
  output logic        full_o,
  output logic        empty_o
);

  localparam int unsigned PtrW = $clog2(Depth);

  frame_desc_t     mem_q [Depth];
  logic [PtrW:0]   wr_ptr_q;
  logic [PtrW:0]   rd_ptr_q;
  logic            do_push;
  logic            do_pop;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign full_o  = (wr_ptr_q[PtrW] != rd_ptr_q[PtrW]) &&
                   (wr_ptr_q[PtrW-1:0] == rd_ptr_q[PtrW-1:0]);
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = mem_q[rd_ptr_q[PtrW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + (PtrW+1)'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + (PtrW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[PtrW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/frame_dispatch.sv
// Forwarding-decision stage: learns the source, looks up the destination and
// enqueues the frame start pointer into the VOQs of the chosen egress ports.
module frame_dispatch
  import switch_pkg::*;
#(
  parameter int unsigned DESC_DEPTH     = 4,
  parameter int unsigned LOOKUP_TIMEOUT = 15
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 desc_valid_i,
  output logic                 desc_ready_o,
  input  logic [PORT_W-1:0]    desc_src_port_i,
  input  logic [MAC_W-1:0]     desc_src_mac_i,
  input  logic [MAC_W-1:0]     desc_dst_mac_i,
  input  logic [ADDR_W-1:0]    desc_start_addr_i,
  output logic                 learn_req_o,
  output logic [MAC_W-1:0]     learn_addr_o,
  output logic [PORT_W-1:0]    learn_port_o,
  output logic                 lookup_req_o,
  output logic [MAC_W-1:0]     lookup_addr_o,
  input  logic                 lookup_done_i,
  input  logic                 lookup_hit_i,
  input  logic [PORT_W-1:0]    lookup_port_i,
  input  logic [NUM_PORTS-1:0] voq_full_i,
  output logic [NUM_PORTS-1:0] voq_write_req_o,
  output logic [ADDR_W-1:0]    voq_ptr_o,
  output logic [CNT_W-1:0]     flood_count_o,
  output logic [CNT_W-1:0]     drop_count_o
);

  localparam int unsigned TimerW = $clog2(LOOKUP_TIMEOUT + 1);

  dispatch_state_t      state_q;
  dispatch_state_t      state_d;
  frame_desc_t          work_q;
  frame_desc_t          work_d;
  frame_desc_t          fifo_wdata;
  frame_desc_t          fifo_rdata;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 fifo_pop;
  logic [NUM_PORTS-1:0] mask_q;
  logic [NUM_PORTS-1:0] mask_d;
  logic [TimerW-1:0]    timer_q;
  logic [TimerW-1:0]    timer_d;
  logic [CNT_W-1:0]     flood_q;
  logic [CNT_W-1:0]     flood_d;
  logic [CNT_W-1:0]     drop_q;
  logic [CNT_W-1:0]     drop_d;
  logic [NUM_PORTS-1:0] flood_mask;
  logic                 timed_out;
  logic                 use_flood;

  function automatic logic [PORT_W:0] popcount(input logic [NUM_PORTS-1:0] v);
    logic [PORT_W:0] n;
    n = '0;
    for (int i = 0; i < NUM_PORTS; i++) n = n + {{PORT_W{1'b0}}, v[i]};
    return n;
  endfunction

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] cnt,
                                               input logic [CNT_W-1:0] inc);
    logic [CNT_W:0] sum;
    sum = {1'b0, cnt} + {1'b0, inc};
    return sum[CNT_W] ? '1 : sum[CNT_W-1:0];
  endfunction

  assign fifo_wdata = '{src_port:   desc_src_port_i,
                        src_mac:    desc_src_mac_i,
                        dst_mac:    desc_dst_mac_i,
                        start_addr: desc_start_addr_i};

  desc_fifo #(
    .Depth(DESC_DEPTH)
  ) u_desc_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (desc_valid_i),
    .wdata_i (fifo_wdata),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign flood_mask = ~port_onehot(work_q.src_port);
  // Timer counts cycles since the lookup strobe; expiry is treated as a miss.
  assign timed_out  = (timer_q == TimerW'(LOOKUP_TIMEOUT - 1));
  assign use_flood  = is_group_mac(work_q.dst_mac) || !(lookup_done_i && lookup_hit_i);

  always_comb begin
    state_d  = state_q;
    work_d   = work_q;
    mask_d   = mask_q;
    timer_d  = timer_q;
    flood_d  = flood_q;
    drop_d   = drop_q;
    fifo_pop = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          work_d   = fifo_rdata;
          state_d  = StLearn;
        end
      end
      StLearn: state_d = StLookup;
      StLookup: begin
        timer_d = TimerW'(1);
        state_d = StWait;
      end
      StWait: begin
        if (lookup_done_i || timed_out) begin
          if (use_flood) begin
            mask_d  = flood_mask;
            flood_d = sat_add(flood_q, CNT_W'(1));
          end else if (lookup_port_i == work_q.src_port) begin
            mask_d = '0;
          end else begin
            mask_d = port_onehot(lookup_port_i);
          end
          state_d = StEnq;
        end else begin
          timer_d = timer_q + TimerW'(1);
        end
      end
      StEnq: begin
        drop_d  = sat_add(drop_q, CNT_W'(popcount(mask_q & voq_full_i)));
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      work_q  <= '0;
      mask_q  <= '0;
      timer_q <= '0;
      flood_q <= '0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      mask_q  <= mask_d;
      timer_q <= timer_d;
      flood_q <= flood_d;
      drop_q  <= drop_d;
    end
  end

  assign desc_ready_o    = !fifo_full;
  assign learn_req_o     = (state_q == StLearn) && !is_group_mac(work_q.src_mac);
  assign learn_addr_o    = work_q.src_mac;
  assign learn_port_o    = work_q.src_port;
  assign lookup_req_o    = (state_q == StLookup);
  assign lookup_addr_o   = work_q.dst_mac;
  assign voq_write_req_o = (state_q == StEnq) ? (mask_q & ~voq_full_i) : '0;
  assign voq_ptr_o       = work_q.start_addr;
  assign flood_count_o   = flood_q;
  assign drop_count_o    = drop_q;

endmodule

// File: tb/tb_frame_dispatch.sv
// Self-checking bench for frame_dispatch: scoreboarded VOQ writes, learn strobes
// and an address-table responder driven from per-descriptor expectations.
module tb_frame_dispatch;
  import switch_pkg::*;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 desc_valid_i = 1'b0;
  logic                 desc_ready_o;
  logic [PORT_W-1:0]    desc_src_port_i = '0;
  logic [MAC_W-1:0]     desc_src_mac_i = '0;
  logic [MAC_W-1:0]     desc_dst_mac_i = '0;
  logic [ADDR_W-1:0]    desc_start_addr_i = '0;
  logic                 learn_req_o;
  logic [MAC_W-1:0]     learn_addr_o;
  logic [PORT_W-1:0]    learn_port_o;
  logic                 lookup_req_o;
  logic [MAC_W-1:0]     lookup_addr_o;
  logic                 lookup_done_i = 1'b0;
  logic                 lookup_hit_i = 1'b0;
  logic [PORT_W-1:0]    lookup_port_i = '0;
  logic [NUM_PORTS-1:0] voq_full_i = '0;
  logic [NUM_PORTS-1:0] voq_write_req_o;
  logic [ADDR_W-1:0]    voq_ptr_o;
  logic [CNT_W-1:0]     flood_count_o;
  logic [CNT_W-1:0]     drop_count_o;

  always #5 clk = ~clk;

  frame_dispatch #(
    .DESC_DEPTH     (4),
    .LOOKUP_TIMEOUT (15)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .desc_valid_i      (desc_valid_i),
    .desc_ready_o      (desc_ready_o),
    .desc_src_port_i   (desc_src_port_i),
    .desc_src_mac_i    (desc_src_mac_i),
    .desc_dst_mac_i    (desc_dst_mac_i),
    .desc_start_addr_i (desc_start_addr_i),
    .learn_req_o       (learn_req_o),
    .learn_addr_o      (learn_addr_o),
    .learn_port_o      (learn_port_o),
    .lookup_req_o      (lookup_req_o),
    .lookup_addr_o     (lookup_addr_o),
    .lookup_done_i     (lookup_done_i),
    .lookup_hit_i      (lookup_hit_i),
    .lookup_port_i     (lookup_port_i),
    .voq_full_i        (voq_full_i),
    .voq_write_req_o   (voq_write_req_o),
    .voq_ptr_o         (voq_ptr_o),
    .flood_count_o     (flood_count_o),
    .drop_count_o      (drop_count_o)
  );

  typedef struct {
    logic [NUM_PORTS-1:0] mask;
    logic [ADDR_W-1:0]    ptr;
  } wr_exp_t;

  typedef struct {
    logic [PORT_W-1:0] port;
    logic [MAC_W-1:0]  mac;
  } learn_exp_t;

  typedef struct {
    bit                respond;
    bit                hit;
    logic [PORT_W-1:0] port;
    logic [MAC_W-1:0]  dmac;
  } resp_t;

  wr_exp_t    wr_q[$];
  learn_exp_t learn_q[$];
  resp_t      resp_q[$];

  int errors = 0;
  int checks = 0;
  int exp_flood = 0;
  int exp_drop = 0;
  int wr_seen = 0;
  bit mon_en = 0;
  bit hold_done = 0;

  // Reference forwarding decision.
  function automatic logic [NUM_PORTS-1:0] model_mask(input logic [PORT_W-1:0] src,
      input logic [MAC_W-1:0] dmac, input bit respond, input bit hit,
      input logic [PORT_W-1:0] port, output bit flood);
    logic [NUM_PORTS-1:0] m;
    m = '0;
    flood = dmac[40] || !respond || !hit;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (flood) m[i] = (i != int'(src));
      else       m[i] = (i == int'(port)) && (port != src);
    end
    return m;
  endfunction

  // VOQ write scoreboard.
  always @(negedge clk) begin
    wr_exp_t e;
    if (mon_en && voq_write_req_o !== '0) begin
      wr_seen++;
      checks++;
      if (wr_q.size() == 0) begin
        errors++;
        $display("FAIL voq_write_unexpected: got mask=%b ptr=%h, required no write",
                 voq_write_req_o, voq_ptr_o);
      end else begin
        e = wr_q.pop_front();
        if (voq_write_req_o !== e.mask || voq_ptr_o !== e.ptr) begin
          errors++;
          $display("FAIL voq_write: got mask=%b ptr=%h, required mask=%b ptr=%h",
                   voq_write_req_o, voq_ptr_o, e.mask, e.ptr);
        end
      end
    end
  end

  // Learn strobe scoreboard.
  always @(negedge clk) begin
    learn_exp_t l;
    if (mon_en && learn_req_o === 1'b1) begin
      checks++;
      if (learn_q.size() == 0) begin
        errors++;
        $display("FAIL learn_unexpected: got addr=%h port=%0d, required no learn",
                 learn_addr_o, learn_port_o);
      end else begin
        l = learn_q.pop_front();
        if (learn_addr_o !== l.mac || learn_port_o !== l.port) begin
          errors++;
          $display("FAIL learn: got addr=%h port=%0d, required addr=%h port=%0d",
                   learn_addr_o, learn_port_o, l.mac, l.port);
        end
      end
    end
  end

  // Address-table model: answers one cycle after the lookup strobe unless held.
  always @(negedge clk) begin
    resp_t r;
    if (mon_en && lookup_req_o === 1'b1) begin
      checks++;
      if (resp_q.size() == 0) begin
        errors++;
        $display("FAIL lookup_unexpected: got addr=%h, required no lookup", lookup_addr_o);
      end else begin
        r = resp_q.pop_front();
        if (lookup_addr_o !== r.dmac) begin
          errors++;
          $display("FAIL lookup_addr: got %h, required %h", lookup_addr_o, r.dmac);
        end
        if (r.respond) begin
          @(negedge clk);
          for (int n = 0; hold_done && n < 100; n++) @(negedge clk);
          lookup_done_i = 1'b1;
          lookup_hit_i  = r.hit;
          lookup_port_i = r.port;
          @(negedge clk);
          lookup_done_i = 1'b0;
          lookup_hit_i  = 1'b0;
          lookup_port_i = '0;
        end
      end
    end
  end

  task automatic send(input logic [PORT_W-1:0] src, input logic [MAC_W-1:0] smac,
                      input logic [MAC_W-1:0] dmac, input logic [ADDR_W-1:0] addr,
                      input bit respond, input bit hit, input logic [PORT_W-1:0] port);
    logic [NUM_PORTS-1:0] m;
    logic [NUM_PORTS-1:0] wr;
    bit fl;
    int n;
    m  = model_mask(src, dmac, respond, hit, port, fl);
    wr = m & ~voq_full_i;
    if (fl) exp_flood++;
    exp_drop += $countones(m & voq_full_i);
    if (wr != '0) wr_q.push_back('{wr, addr});
    if (!smac[40]) learn_q.push_back('{src, smac});
    resp_q.push_back('{respond, hit, port, dmac});
    n = 0;
    while (desc_ready_o !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      checks++;
      errors++;
      $display("FAIL push_timeout: got desc_ready_o=%b, required 1", desc_ready_o);
    end
    desc_valid_i      = 1'b1;
    desc_src_port_i   = src;
    desc_src_mac_i    = smac;
    desc_dst_mac_i    = dmac;
    desc_start_addr_i = addr;
    @(negedge clk);
    desc_valid_i = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((wr_q.size() != 0 || resp_q.size() != 0) && n < 400) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 400) begin
      errors++;
      $display("FAIL drain: got %0d writes %0d lookups pending, required 0",
               wr_q.size(), resp_q.size());
    end
    repeat (6) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (desc_ready_o !== 1'b1 || learn_req_o !== 1'b0 || lookup_req_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got ready=%b learn=%b lookup=%b, required 1 0 0",
               desc_ready_o, learn_req_o, lookup_req_o);
    end
    checks++;
    if (voq_write_req_o !== '0 || flood_count_o !== '0 || drop_count_o !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got wr=%b flood=%0d drop=%0d, required 0 0 0",
               voq_write_req_o, flood_count_o, drop_count_o);
    end
    rst    = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_unicast();
    send(0, 48'h02_00_00_00_00_0A, 48'h02_00_00_00_00_0B, 10'h005, 1, 1, 2);
    checks++;
    if (learn_req_o !== 1'b0) begin
      errors++;
      $display("FAIL uni_learn_early: got %b, required 0", learn_req_o);
    end
    @(negedge clk);
    checks++;
    if (learn_req_o !== 1'b1 || learn_addr_o !== 48'h02_00_00_00_00_0A || learn_port_o !== 0) begin
      errors++;
      $display("FAIL uni_learn_t1: got req=%b addr=%h port=%0d, required 1 02000000000a 0",
               learn_req_o, learn_addr_o, learn_port_o);
    end
    @(negedge clk);
    checks++;
    if (lookup_req_o !== 1'b1 || lookup_addr_o !== 48'h02_00_00_00_00_0B) begin
      errors++;
      $display("FAIL uni_lookup_t2: got req=%b addr=%h, required 1 02000000000b",
               lookup_req_o, lookup_addr_o);
    end
    @(negedge clk);
    checks++;
    if (voq_write_req_o !== '0) begin
      errors++;
      $display("FAIL uni_write_early: got %b, required 0000", voq_write_req_o);
    end
    @(negedge clk);
    checks++;
    if (voq_write_req_o !== 4'b0100 || voq_ptr_o !== 10'h005) begin
      errors++;
      $display("FAIL uni_write_t4: got mask=%b ptr=%h, required 0100 005",
               voq_write_req_o, voq_ptr_o);
    end
    drain();
    checks++;
    if (flood_count_o !== 16'(exp_flood) || drop_count_o !== 16'(exp_drop)) begin
      errors++;
      $display("FAIL uni_counts: got flood=%0d drop=%0d, required %0d %0d",
               flood_count_o, drop_count_o, exp_flood, exp_drop);
    end
  endtask

  task automatic test_flood();
    // Group destination floods even when the table reports a hit.
    send(1, 48'h02_00_00_00_00_11, 48'hFF_FF_FF_FF_FF_FF, 10'h010, 1, 1, 3);
    send(3, 48'h02_00_00_00_00_13, 48'h02_00_00_00_00_0C, 10'h011, 1, 0, 0);
    drain();
    checks++;
    if (flood_count_o !== 16'(exp_flood) || exp_flood != 2) begin
      errors++;
      $display("FAIL flood_count: got %0d, required 2", flood_count_o);
    end
  endtask

  task automatic test_filter_full();
    int seen0;
    int drop0;
    seen0 = wr_seen;
    drop0 = drop_count_o;
    send(2, 48'h02_00_00_00_00_22, 48'h02_00_00_00_00_0D, 10'h020, 1, 1, 2);
    drain();
    checks++;
    if (wr_seen != seen0 || flood_count_o !== 16'(exp_flood) || drop_count_o !== 16'(drop0)) begin
      errors++;
      $display("FAIL filter: got writes=%0d flood=%0d drop=%0d, required %0d %0d %0d",
               wr_seen - seen0, flood_count_o, drop_count_o, 0, exp_flood, drop0);
    end
    voq_full_i = 4'b0100;
    send(0, 48'h02_00_00_00_00_20, 48'hFF_FF_FF_FF_FF_FF, 10'h021, 1, 0, 0);
    drain();
    voq_full_i = '0;
    checks++;
    if (drop_count_o !== 16'd1 || drop_count_o !== 16'(exp_drop) || flood_count_o !== 16'd3) begin
      errors++;
      $display("FAIL full_drop: got drop=%0d flood=%0d, required 1 3",
               drop_count_o, flood_count_o);
    end
  endtask

  task automatic test_back_to_back();
    hold_done = 1'b1;
    for (int i = 0; i < 5; i++) begin
      send(PORT_W'(i % 4), 48'h02_00_00_00_02_00 + 48'(i), 48'h02_00_00_00_01_00 + 48'(i),
           ADDR_W'(i), 1, 1, PORT_W'((i + 1) % 4));
    end
    checks++;
    if (desc_ready_o !== 1'b0) begin
      errors++;
      $display("FAIL b2b_ready_full: got %b, required 0", desc_ready_o);
    end
    hold_done = 1'b0;
    send(1, 48'h02_00_00_00_02_05, 48'h02_00_00_00_01_05, 10'd5, 1, 1, 2);
    drain();
    checks++;
    if (learn_q.size() != 0) begin
      errors++;
      $display("FAIL b2b_learns: got %0d pending, required 0", learn_q.size());
    end
  endtask

  task automatic test_timeout_group();
    int n;
    int cnt;
    send(1, 48'h02_00_00_00_00_30, 48'h02_00_00_00_00_31, 10'h030, 0, 0, 0);
    n = 0;
    while (lookup_req_o !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    cnt = 0;
    while (voq_write_req_o === '0 && cnt < 40) begin
      @(negedge clk);
      cnt++;
    end
    checks++;
    if (n >= 20 || cnt != 15) begin
      errors++;
      $display("FAIL timeout_latency: got %0d cycles after lookup, required 15", cnt);
    end
    send(2, 48'h01_00_5E_00_00_01, 48'h02_00_00_00_00_41, 10'h031, 1, 1, 0);
    @(negedge clk);
    checks++;
    if (learn_req_o !== 1'b0) begin
      errors++;
      $display("FAIL group_src_learn: got %b, required 0", learn_req_o);
    end
    drain();
    checks++;
    if (flood_count_o !== 16'(exp_flood)) begin
      errors++;
      $display("FAIL timeout_flood: got %0d, required %0d", flood_count_o, exp_flood);
    end
  endtask

  task automatic test_reset_wait();
    int n;
    int stray;
    send(3, 48'h02_00_00_00_00_50, 48'h02_00_00_00_00_51, 10'h040, 0, 0, 0);
    n = 0;
    while (lookup_req_o !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    // The working descriptor is abandoned, so its expectations go too.
    wr_q.delete();
    learn_q.delete();
    resp_q.delete();
    exp_flood = 0;
    exp_drop  = 0;
    checks++;
    if (desc_ready_o !== 1'b1 || flood_count_o !== '0 || drop_count_o !== '0) begin
      errors++;
      $display("FAIL rst_wait_state: got ready=%b flood=%0d drop=%0d, required 1 0 0",
               desc_ready_o, flood_count_o, drop_count_o);
    end
    stray = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (voq_write_req_o !== '0) stray++;
    end
    checks++;
    if (stray != 0) begin
      errors++;
      $display("FAIL rst_wait_partial: got %0d write cycles, required 0", stray);
    end
    send(0, 48'h02_00_00_00_00_60, 48'h02_00_00_00_00_61, 10'h041, 1, 1, 3);
    repeat (2) @(negedge clk);
    checks++;
    if (lookup_req_o !== 1'b1) begin
      errors++;
      $display("FAIL rst_next_lookup: got %b, required 1", lookup_req_o);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (voq_write_req_o !== 4'b1000 || voq_ptr_o !== 10'h041) begin
      errors++;
      $display("FAIL rst_next_write: got mask=%b ptr=%h, required 1000 041",
               voq_write_req_o, voq_ptr_o);
    end
    drain();
  endtask

  initial begin
    test_reset();
    test_unicast();
    test_flood();
    test_filter_full();
    test_back_to_back();
    test_timeout_group();
    test_reset_wait();
    checks++;
    if (wr_q.size() != 0 || learn_q.size() != 0 || resp_q.size() != 0) begin
      errors++;
      $display("FAIL leftovers: got wr=%0d learn=%0d lookup=%0d, required 0 0 0",
               wr_q.size(), learn_q.size(), resp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion by 200000 ns, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
